// File: rtl/dis_wei_pkg.sv
// Shared sizing and FSM state type for the weight distributor.
package dis_wei_pkg;

  localparam int unsigned DW_NUMFLG = 32;
  localparam int unsigned DW_WEIW   = 8;
  localparam int unsigned DW_WPW    = 8;
  localparam int unsigned DW_ADDRW  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDFLG,
    ST_WTFLG,
    ST_RDWEI,
    ST_DONE
  } dw_state_e;

  function automatic int unsigned dw_ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dis_wei_popcnt.sv
// Combinational population count of the bundle flag word.
module dis_wei_popcnt #(
  parameter int unsigned NUMFLG = 32,
  parameter int unsigned CNTW   = $clog2(NUMFLG) + 1
) (
  input  logic [NUMFLG-1:0] flg_i,
  output logic [CNTW-1:0]   cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < NUMFLG; i++) begin
      cnt_o = cnt_o + CNTW'(flg_i[i]);
    end
  end

endmodule

// File: rtl/dis_wei.sv
// Weight distributor: fetches one flag word plus its packed non-zero weights
// from the global buffers per fetch request and holds the assembled bundle.
module dis_wei
  import dis_wei_pkg::*;
#(
  parameter  int unsigned NUMFLG = DW_NUMFLG,
  parameter  int unsigned WEIW   = DW_WEIW,
  parameter  int unsigned WPW    = DW_WPW,
  parameter  int unsigned ADDRW  = DW_ADDRW,
  localparam int unsigned CNTW   = $clog2(NUMFLG) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CTRLWEI_PlsFetch,
  input  logic                   CTRLACT_FnhFrm,
  input  logic                   GBFFLGWEI_Val,
  output logic                   GBFFLGWEI_Rd,
  output logic [ADDRW-1:0]       GBFFLGWEI_Addr,
  input  logic [NUMFLG-1:0]      GBFFLGWEI_Dat,
  input  logic                   GBFWEI_Val,
  output logic                   GBFWEI_Rd,
  output logic [ADDRW-1:0]       GBFWEI_Addr,
  input  logic [WPW*WEIW-1:0]    GBFWEI_Dat,
  output logic                   DISWEI_RdyWei,
  output logic [NUMFLG-1:0]      DISWEIPEC_Flg,
  output logic [NUMFLG*WEIW-1:0] DISWEIPEC_Wei,
  output logic [CNTW-1:0]        DISWEIPEC_NumWei,
  output logic                   DISWEI_Ovf
);

  localparam int unsigned WRDW  = WPW * WEIW;
  localparam int unsigned NWRD  = dw_ceil_div(NUMFLG, WPW);
  localparam int unsigned PACKW = NWRD * WRDW;

  dw_state_e          state_q, state_d;
  logic [ADDRW-1:0]   faddr_q, faddr_d;
  logic [ADDRW-1:0]   waddr_q, waddr_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic [NUMFLG-1:0]  flg_q, flg_d;
  logic [PACKW-1:0]   wei_q, wei_d;
  logic [CNTW-1:0]    num_q, num_d;
  logic [CNTW-1:0]    nwrd_q, nwrd_d;
  logic [CNTW-1:0]    iss_q, iss_d;
  logic [CNTW-1:0]    cap_q, cap_d;
  logic               wvld_q, wvld_d;

  logic [CNTW-1:0]    pop;
  logic               frd, wrd, start, direct, consume;

  dis_wei_popcnt #(
    .NUMFLG (NUMFLG),
    .CNTW   (CNTW)
  ) u_popcnt (
    .flg_i (GBFFLGWEI_Dat),
    .cnt_o (pop)
  );

  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    waddr_d = waddr_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    flg_d   = flg_q;
    wei_d   = wei_q;
    num_d   = num_q;
    nwrd_d  = nwrd_q;
    iss_d   = iss_q;
    cap_d   = cap_q;

    frd     = (state_q == ST_RDFLG) && GBFFLGWEI_Val && !CTRLACT_FnhFrm;
    wrd     = (state_q == ST_RDWEI) && GBFWEI_Val && (iss_q < nwrd_q) && !CTRLACT_FnhFrm;
    wvld_d  = wrd;

    // A fetch starts a load directly only from IDLE/DONE with nothing queued;
    // otherwise it occupies the single pending slot or, if that is full, is dropped.
    direct  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !pend_q;
    consume = (state_q == ST_IDLE) && pend_q;
    start   = (direct && CTRLWEI_PlsFetch) || consume;

    if (consume) pend_d = 1'b0;
    if (CTRLWEI_PlsFetch && !direct) begin
      if (pend_q && !consume) ovf_d = 1'b1;
      else                    pend_d = 1'b1;
    end

    if (frd) faddr_d = faddr_q + ADDRW'(1);
    if (wrd) begin
      waddr_d = waddr_q + ADDRW'(1);
      iss_d   = iss_q + CNTW'(1);
    end

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RDFLG;
      ST_RDFLG: if (frd) state_d = ST_WTFLG;
      ST_WTFLG: begin
        flg_d   = GBFFLGWEI_Dat;
        num_d   = pop;
        nwrd_d  = CNTW'((32'(pop) + WPW - 1) / WPW);
        iss_d   = '0;
        cap_d   = '0;
        state_d = (pop == '0) ? ST_DONE : ST_RDWEI;
      end
      ST_RDWEI: begin
        if (wvld_q) begin
          for (int unsigned k = 0; k < NWRD; k++) begin
            if (cap_q == CNTW'(k)) wei_d[k*WRDW +: WRDW] = GBFWEI_Dat;
          end
          cap_d = cap_q + CNTW'(1);
          if (cap_q + CNTW'(1) == nwrd_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start)       state_d = ST_RDFLG;
        else if (pend_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      flg_d = '0;
      wei_d = '0;
      num_d = '0;
    end

    // Frame end overrides everything; a simultaneous fetch becomes the pending load.
    if (CTRLACT_FnhFrm) begin
      state_d = ST_IDLE;
      faddr_d = '0;
      waddr_d = '0;
      pend_d  = CTRLWEI_PlsFetch;
      ovf_d   = ovf_q;
      wvld_d  = 1'b0;
      flg_d   = flg_q;
      wei_d   = wei_q;
      num_d   = num_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      faddr_q <= '0;
      waddr_q <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      flg_q   <= '0;
      wei_q   <= '0;
      num_q   <= '0;
      nwrd_q  <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      wvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      waddr_q <= waddr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      flg_q   <= flg_d;
      wei_q   <= wei_d;
      num_q   <= num_d;
      nwrd_q  <= nwrd_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      wvld_q  <= wvld_d;
    end
  end

  assign GBFFLGWEI_Rd     = frd;
  assign GBFFLGWEI_Addr   = faddr_q;
  assign GBFWEI_Rd        = wrd;
  assign GBFWEI_Addr      = waddr_q;
  assign DISWEI_RdyWei    = (state_q == ST_DONE);
  assign DISWEIPEC_Flg    = flg_q;
  assign DISWEIPEC_Wei    = wei_q[NUMFLG*WEIW-1:0];
  assign DISWEIPEC_NumWei = num_q;
  assign DISWEI_Ovf       = ovf_q;

endmodule

// File: tb/tb_dis_wei.sv
// Self-checking bench for dis_wei: emulated global buffers plus a bundle-level model.
module tb_dis_wei;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch, fnh, fval, wval;
  logic         frd, wrd, rdy, ovf;
  logic [9:0]   faddr, waddr;
  logic [31:0]  fdat, flg;
  logic [63:0]  wdat;
  logic [255:0] wei;
  logic [5:0]   numwei;

  dis_wei dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .CTRLWEI_PlsFetch (fetch),
    .CTRLACT_FnhFrm   (fnh),
    .GBFFLGWEI_Val    (fval),
    .GBFFLGWEI_Rd     (frd),
    .GBFFLGWEI_Addr   (faddr),
    .GBFFLGWEI_Dat    (fdat),
    .GBFWEI_Val       (wval),
    .GBFWEI_Rd        (wrd),
    .GBFWEI_Addr      (waddr),
    .GBFWEI_Dat       (wdat),
    .DISWEI_RdyWei    (rdy),
    .DISWEIPEC_Flg    (flg),
    .DISWEIPEC_Wei    (wei),
    .DISWEIPEC_NumWei (numwei),
    .DISWEI_Ovf       (ovf)
  );

  always #5 clk = ~clk;

  logic [31:0] flag_mem [1024];
  logic [63:0] wei_mem  [1024];
  int unsigned frd_cnt = 0, wrd_cnt = 0;
  int unsigned fq[$], wq[$];

  // Global-buffer emulation: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (frd) begin
      fdat <= flag_mem[faddr];
      fq.push_back(32'(faddr));
      frd_cnt <= frd_cnt + 1;
    end
    if (wrd) begin
      wdat <= wei_mem[waddr];
      wq.push_back(32'(waddr));
      wrd_cnt <= wrd_cnt + 1;
    end
  end

  int unsigned n_chk = 0, n_pass = 0;
  int unsigned exp_fa = 0, exp_wa = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bundle reference: flag word, its popcount, word count and the packed weights.
  function automatic void model(input int unsigned fa, input int unsigned wa,
                                output logic [31:0] f, output int unsigned n,
                                output int unsigned w, output logic [255:0] pk);
    f  = flag_mem[fa % 1024];
    n  = $countones(f);
    w  = (n + 7) / 8;
    pk = '0;
    for (int unsigned k = 0; k < w; k++) pk[k*64 +: 64] = wei_mem[(wa + k) % 1024];
  endfunction

  task automatic wait_level(input logic lvl);
    int unsigned t = 0;
    while (rdy !== lvl && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("wait_rdy", 256'(rdy), 256'(lvl));
  endtask

  task automatic check_bundle(input string tag, input logic [31:0] f, input int unsigned n,
                              input logic [255:0] pk);
    check({tag, "_flg"}, 256'(flg), 256'(f));
    check({tag, "_num"}, 256'(numwei), 256'(n));
    check({tag, "_wei"}, wei, pk);
  endtask

  task automatic run_bundle(input bit pulse, input bit chk, input int unsigned stall,
                            input bit rnd, output int unsigned lat);
    logic [31:0]  ef;
    logic [255:0] ewei;
    int unsigned  en, ew, fr0, wr0, left;
    model(exp_fa, exp_wa, ef, en, ew, ewei);
    @(negedge clk);
    fq.delete();
    wq.delete();
    fr0  = frd_cnt;
    wr0  = wrd_cnt;
    left = stall;
    if (pulse) fetch = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      fetch = 1'b0;
      lat++;
      if (rnd) begin
        fval = ($urandom_range(0, 3) != 0);
        wval = ($urandom_range(0, 3) != 0);
      end else if (left > 0 && wrd_cnt > wr0) begin
        wval = 1'b0;
        left--;
      end else begin
        wval = 1'b1;
      end
    end while (!rdy && lat < 300);
    fval = 1'b1;
    wval = 1'b1;
    check("rdy_timeout", 256'(rdy), 256'd1);
    if (chk) begin
      check_bundle("bundle", ef, en, ewei);
      check("flag_reads", 256'(frd_cnt - fr0), 256'd1);
      check("wei_reads", 256'(wrd_cnt - wr0), 256'(ew));
      if (fq.size() > 0) check("flag_addr", 256'(fq[0]), 256'(exp_fa));
      for (int unsigned k = 0; k < wq.size() && k < ew; k++)
        check("wei_addr", 256'(wq[k]), 256'((exp_wa + k) % 1024));
    end
    exp_fa = (exp_fa + 1) % 1024;
    exp_wa = (exp_wa + ew) % 1024;
  endtask

  typedef struct {
    logic [31:0] flag;
    int unsigned stall;
    int unsigned num;
    int unsigned lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int unsigned  lat, fr0, wr0, t, nA, wA, nB, wB;
    logic [31:0]  fA, fB;
    logic [255:0] pA, pB;
    bit           seen;

    vecs[0] = '{32'h0000_00FF, 0,  8, 5};
    vecs[1] = '{32'h0000_0000, 0,  0, 3};
    vecs[2] = '{32'hFFFF_FFFF, 0, 32, 8};
    vecs[3] = '{32'h0000_FFFF, 3, 16, 9};
    vecs[4] = '{32'h0000_FFFF, 0, 16, 6};

    for (int unsigned i = 0; i < 1024; i++) begin
      flag_mem[i] = $urandom & $urandom;
      wei_mem[i]  = {$urandom, $urandom};
    end
    wei_mem[0] = 64'h0807_0605_0403_0201;

    rst_n = 1'b0; fetch = 1'b0; fnh = 1'b0; fval = 1'b1; wval = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy", 256'(rdy), 256'd0);
    check("rst_wei", wei, 256'd0);
    check("rst_flg", 256'(flg), 256'd0);
    check("rst_ovf", 256'(ovf), 256'd0);
    check("rst_faddr", 256'(faddr), 256'd0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 5; i++) begin
      flag_mem[exp_fa] = vecs[i].flag;
      run_bundle(1'b1, 1'b1, vecs[i].stall, 1'b0, lat);
      check("vec_num", 256'(numwei), 256'(vecs[i].num));
      check("vec_lat", 256'(lat), 256'(vecs[i].lat));
      if (i == 0) check("t1_wei", wei, 256'h0807_0605_0403_0201);
    end

    // Frame end in the middle of a weight load, flag address 5.
    flag_mem[exp_fa] = '1;
    @(negedge clk);
    fq.delete();
    wr0 = wrd_cnt;
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    t = 0;
    while (wrd_cnt == wr0 && t < 50) begin @(negedge clk); t++; end
    if (fq.size() > 0) check("abort_flag_addr", 256'(fq[0]), 256'(exp_fa));
    fnh = 1'b1;
    @(negedge clk);
    fnh = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (rdy) seen = 1'b1; end
    check("abort_rdy", 256'(seen), 256'd0);
    check("abort_faddr", 256'(faddr), 256'd0);
    check("abort_waddr", 256'(waddr), 256'd0);
    exp_fa = 0; exp_wa = 0;
    run_bundle(1'b1, 1'b1, 0, 1'b0, lat);

    // Frame end together with a fetch: restarts from address 0 on its own.
    flag_mem[exp_fa] = '1;
    @(negedge clk);
    wr0 = wrd_cnt;
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    t = 0;
    while (wrd_cnt == wr0 && t < 50) begin @(negedge clk); t++; end
    fnh = 1'b1; fetch = 1'b1;
    @(negedge clk);
    fnh = 1'b0; fetch = 1'b0;
    exp_fa = 0; exp_wa = 0;
    run_bundle(1'b0, 1'b1, 0, 1'b0, lat);

    // Two fetches during a busy load: one queued, one dropped.
    check("ovf_pre", 256'(ovf), 256'd0);
    flag_mem[exp_fa] = '1;
    flag_mem[(exp_fa + 1) % 1024] = 32'h00F0_0F0F;
    model(exp_fa, exp_wa, fA, nA, wA, pA);
    model(exp_fa + 1, exp_wa + wA, fB, nB, wB, pB);
    @(negedge clk);
    fr0 = frd_cnt; wr0 = wrd_cnt;
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    t = 0;
    while (wrd_cnt == wr0 && t < 50) begin @(negedge clk); t++; end
    fetch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fetch = 1'b0;
    wait_level(1'b1);
    check_bundle("pendA", fA, nA, pA);
    wait_level(1'b0);
    wait_level(1'b1);
    check_bundle("pendB", fB, nB, pB);
    repeat (20) @(negedge clk);
    check("pend_flag_reads", 256'(frd_cnt - fr0), 256'd2);
    check("pend_wei_reads", 256'(wrd_cnt - wr0), 256'(wA + wB));
    check("ovf_post", 256'(ovf), 256'd1);
    exp_fa = (exp_fa + 2) % 1024;
    exp_wa = (exp_wa + wA + wB) % 1024;

    // Random flags and random buffer-valid stalls.
    for (int unsigned i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       flag_mem[exp_fa] = '0;
        1:       flag_mem[exp_fa] = '1;
        default: flag_mem[exp_fa] = $urandom & $urandom;
      endcase
      run_bundle(1'b1, 1'b1, 0, 1'b1, lat);
    end

    // Walk the flag address up to the wrap point.
    while (exp_fa != 1023) run_bundle(1'b1, 1'b0, 0, 1'b0, lat);
    run_bundle(1'b1, 1'b1, 0, 1'b0, lat);
    run_bundle(1'b1, 1'b1, 0, 1'b0, lat);

    // Reset in the middle of a load.
    flag_mem[exp_fa] = '1;
    @(negedge clk);
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    fr0 = frd_cnt; wr0 = wrd_cnt;
    repeat (3) @(negedge clk);
    check("mrst_rdy", 256'(rdy), 256'd0);
    check("mrst_wei", wei, 256'd0);
    check("mrst_num", 256'(numwei), 256'd0);
    check("mrst_ovf", 256'(ovf), 256'd0);
    check("mrst_waddr", 256'(waddr), 256'd0);
    check("mrst_strobes", 256'((frd_cnt - fr0) + (wrd_cnt - wr0)), 256'd0);
    rst_n = 1'b1;
    exp_fa = 0; exp_wa = 0;
    run_bundle(1'b1, 1'b1, 0, 1'b0, lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
